req_arbiter4: RTL and testbench

Four-requester bus arbiter for a single shared resource. It uses a 4-to-2 priority encoder as its arbitration core and adds registered one-hot grants, grant locking, a hold-time limit with preemption, and a selectable fixed-priority or round-robin policy. It sits between the requesting client blocks and the shared datapath; the encoded `gnt_id` drives the datapath's input-select mux.

---
 rtl/req_arbiter4_pkg.sv | 32 +++
 rtl/req_arbiter4_prio_enc.sv | 26 ++
 rtl/req_arbiter4.sv | 132 +++++++++++++
 tb/tb_req_arbiter4.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/req_arbiter4_pkg.sv
// Shared definitions for the four-requester arbiter: FSM states, requester count
// and small helpers for one-hot conversion and round-robin rotation.
package req_arbiter4_pkg;

    localparam int N_REQ = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_GAP   = 2'd2
    } arb_state_e;

    function automatic logic [N_REQ-1:0] id_to_onehot(input logic [1:0] id);
        logic [N_REQ-1:0] v;
        v     = 4'b0000;
        v[id] = 1'b1;
        return v;
    endfunction

    // Bit 3 of the result is the first candidate after ptr and bit 0 is ptr itself,
    // so the fixed-priority encoder walks ptr+1, ptr+2, ptr+3, ptr.
    function automatic logic [N_REQ-1:0] rr_rotate(input logic [N_REQ-1:0] vec,
                                                   input logic [1:0]       ptr);
        logic [N_REQ-1:0] r;
        r = 4'b0000;
        for (int k = 0; k < N_REQ; k++) begin
            r[k] = vec[ptr - 2'(k)];
        end
        return r;
    endfunction

endpackage

// File: rtl/req_arbiter4_prio_enc.sv
// Combinational 4-to-2 priority encoder, bit 3 highest, with a valid flag.
module prio_enc4_v
    import req_arbiter4_pkg::*;
(
    input  logic [N_REQ-1:0] req_vec,
    output logic [1:0]       idx,
    output logic             any
);

    // Highest set bit wins.
    always_comb begin
        idx = 2'd0;
        any = 1'b1;
        casez (req_vec)
            4'b1???: idx = 2'd3;
            4'b01??: idx = 2'd2;
            4'b001?: idx = 2'd1;
            4'b0001: idx = 2'd0;
            default: begin
                idx = 2'd0;
                any = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/req_arbiter4.sv
// Four-requester arbiter: registered one-hot grant with locking, hold-time
// preemption through a one-cycle gap, and fixed or round-robin selection.
module req_arbiter4
    import req_arbiter4_pkg::*;
#(
    parameter int MAX_HOLD = 8,
    parameter int CW       = 8
)
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] req,
    input  logic             rr_en,
    output logic [N_REQ-1:0] gnt,
    output logic [1:0]       gnt_id,
    output logic             gnt_vld
);

    arb_state_e       state_r, state_s;
    logic [CW-1:0]    hold_cnt_r, hold_cnt_s;
    logic [1:0]       rr_ptr_r, rr_ptr_s;
    logic [1:0]       pre_id_r, pre_id_s;
    logic [1:0]       gnt_id_s;
    logic [N_REQ-1:0] gap_masked_s, arb_req_s, enc_in_s;
    logic [1:0]       enc_idx_s, win_id_s;
    logic             enc_any_s;

    // Candidate vector: after a preemption the preempted id sits out unless alone.
    always_comb begin
        gap_masked_s = req & ~id_to_onehot(pre_id_r);
        if (state_r == ST_GAP && gap_masked_s != 4'b0000) begin
            arb_req_s = gap_masked_s;
        end else begin
            arb_req_s = req;
        end
        if (rr_en) begin
            enc_in_s = rr_rotate(arb_req_s, rr_ptr_r);
        end else begin
            enc_in_s = arb_req_s;
        end
    end

    prio_enc4_v u_prio_enc (
        .req_vec (enc_in_s),
        .idx     (enc_idx_s),
        .any     (enc_any_s)
    );

    // Map the encoder position back to a requester index.
    always_comb begin
        if (rr_en) begin
            win_id_s = rr_ptr_r - enc_idx_s;
        end else begin
            win_id_s = enc_idx_s;
        end
    end

    // Next-state, hold counter, pointer and holder id.
    always_comb begin
        state_s    = state_r;
        hold_cnt_s = hold_cnt_r;
        rr_ptr_s   = rr_ptr_r;
        pre_id_s   = pre_id_r;
        gnt_id_s   = gnt_id;
        case (state_r)
            ST_IDLE, ST_GAP: begin
                if (enc_any_s) begin
                    state_s    = ST_GRANT;
                    hold_cnt_s = CW'(1);
                    rr_ptr_s   = win_id_s;
                    gnt_id_s   = win_id_s;
                end else begin
                    state_s    = ST_IDLE;
                    hold_cnt_s = '0;
                end
            end
            ST_GRANT: begin
                // Release beats the hold limit, so a dropped holder never causes a gap.
                if (!req[gnt_id]) begin
                    if (enc_any_s) begin
                        hold_cnt_s = CW'(1);
                        rr_ptr_s   = win_id_s;
                        gnt_id_s   = win_id_s;
                    end else begin
                        state_s    = ST_IDLE;
                        hold_cnt_s = '0;
                    end
                end else if (hold_cnt_r == CW'(MAX_HOLD) &&
                             (req & ~id_to_onehot(gnt_id)) != 4'b0000) begin
                    state_s    = ST_GAP;
                    hold_cnt_s = '0;
                    pre_id_s   = gnt_id;
                end else if (hold_cnt_r == CW'(MAX_HOLD)) begin
                    hold_cnt_s = hold_cnt_r;
                end else begin
                    hold_cnt_s = hold_cnt_r + CW'(1);
                end
            end
            default: begin
                state_s    = ST_IDLE;
                hold_cnt_s = '0;
            end
        endcase
    end

    // State and output registers; outputs are derived from the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= ST_IDLE;
            hold_cnt_r <= '0;
            rr_ptr_r   <= 2'd3;
            pre_id_r   <= 2'd0;
            gnt        <= 4'b0000;
            gnt_id     <= 2'd0;
            gnt_vld    <= 1'b0;
        end else begin
            state_r    <= state_s;
            hold_cnt_r <= hold_cnt_s;
            rr_ptr_r   <= rr_ptr_s;
            pre_id_r   <= pre_id_s;
            gnt_id     <= gnt_id_s;
            if (state_s == ST_GRANT) begin
                gnt     <= id_to_onehot(gnt_id_s);
                gnt_vld <= 1'b1;
            end else begin
                gnt     <= 4'b0000;
                gnt_vld <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_req_arbiter4.sv
// Directed-vector bench for req_arbiter4 using three instances with
// MAX_HOLD of 8, 2 and 3 driven from shared inputs.
module tb_req_arbiter4;

    logic       clk;
    logic       rst_n;
    logic [3:0] req;
    logic       rr_en;

    logic [3:0] gnt8, gnt2, gnt3;
    logic [1:0] id8, id2, id3;
    logic       vld8, vld2, vld3;

    int checks;
    int failures;

    req_arbiter4 #(.MAX_HOLD(8), .CW(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .req(req), .rr_en(rr_en),
        .gnt(gnt8), .gnt_id(id8), .gnt_vld(vld8)
    );
    req_arbiter4 #(.MAX_HOLD(2), .CW(8)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .req(req), .rr_en(rr_en),
        .gnt(gnt2), .gnt_id(id2), .gnt_vld(vld2)
    );
    req_arbiter4 #(.MAX_HOLD(3), .CW(8)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .req(req), .rr_en(rr_en),
        .gnt(gnt3), .gnt_id(id3), .gnt_vld(vld3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req   = 4'b0000;
        rr_en = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    logic [3:0] rr_seq [13] = '{4'b0001, 4'b0001, 4'b0000, 4'b0010, 4'b0010, 4'b0000,
                                4'b0100, 4'b0100, 4'b0000, 4'b1000, 4'b1000, 4'b0000,
                                4'b0001};
    logic [3:0] pre_seq [9] = '{4'b1000, 4'b1000, 4'b1000, 4'b0000,
                                4'b0001, 4'b0001, 4'b0001, 4'b0000, 4'b1000};

    initial begin
        checks   = 0;
        failures = 0;

        // Reset values
        do_reset();
        check_eq("rst_gnt", {4'b0, gnt8}, 8'h00);
        check_eq("rst_id", {6'b0, id8}, 8'h00);
        check_eq("rst_vld", {7'b0, vld8}, 8'h00);

        // First grant one edge after release, then asynchronous reset mid-grant
        req = 4'b1111;
        tick();
        check_eq("fix_first_gnt", {4'b0, gnt8}, 8'h08);
        check_eq("fix_first_id", {6'b0, id8}, 8'h03);
        tick();
        #2 rst_n = 1'b0;
        #1;
        check_eq("async_rst_gnt", {4'b0, gnt8}, 8'h00);
        check_eq("async_rst_vld", {7'b0, vld8}, 8'h00);
        #1 rst_n = 1'b1;
        tick();
        check_eq("post_rst_gnt", {4'b0, gnt8}, 8'h08);
        check_eq("post_rst_vld", {7'b0, vld8}, 8'h01);

        // Fixed priority and zero-gap handoff
        do_reset();
        req = 4'b0110;
        tick();
        check_eq("fix_0110_gnt", {4'b0, gnt8}, 8'h04);
        check_eq("fix_0110_id", {6'b0, id8}, 8'h02);
        req = 4'b0010;
        tick();
        check_eq("handoff_gnt", {4'b0, gnt8}, 8'h02);
        check_eq("handoff_id", {6'b0, id8}, 8'h01);
        check_eq("handoff_vld", {7'b0, vld8}, 8'h01);
        req = 4'b0000;
        tick();
        check_eq("idle_gnt", {4'b0, gnt8}, 8'h00);
        check_eq("idle_id_held", {6'b0, id8}, 8'h01);

        // Round-robin with MAX_HOLD=2: order 0,1,2,3,0 with one gap cycle each
        do_reset();
        rr_en = 1'b1;
        req   = 4'b1111;
        for (int i = 0; i < 13; i++) begin
            tick();
            check_eq($sformatf("rr_gnt_%0d", i), {4'b0, gnt2}, {4'b0, rr_seq[i]});
            if (i == 2) check_eq("rr_gap_id_held", {6'b0, id2}, 8'h00);
            if (i == 2) check_eq("rr_gap_vld", {7'b0, vld2}, 8'h00);
        end

        // Sole requester is never preempted
        do_reset();
        req = 4'b0001;
        for (int i = 0; i < 20; i++) begin
            tick();
            check_eq($sformatf("sole_gnt_%0d", i), {4'b0, gnt8}, 8'h01);
        end

        // Fixed-mode preemption masking with MAX_HOLD=3
        do_reset();
        req = 4'b1001;
        for (int i = 0; i < 9; i++) begin
            tick();
            check_eq($sformatf("pre_gnt_%0d", i), {4'b0, gnt3}, {4'b0, pre_seq[i]});
        end

        // Release coinciding with the hold limit: no gap
        do_reset();
        req = 4'b1001;
        tick();
        tick();
        tick();
        check_eq("lim_hold3_gnt", {4'b0, gnt3}, 8'h08);
        req = 4'b0001;
        tick();
        check_eq("lim_release_gnt", {4'b0, gnt3}, 8'h01);
        check_eq("lim_release_id", {6'b0, id3}, 8'h00);

        // Preempted id regains the grant when it is alone at the gap edge
        do_reset();
        req = 4'b1001;
        tick();
        tick();
        tick();
        tick();
        check_eq("gap_gnt", {4'b0, gnt3}, 8'h00);
        req = 4'b1000;
        tick();
        check_eq("gap_alone_gnt", {4'b0, gnt3}, 8'h08);
        check_eq("gap_alone_id", {6'b0, id3}, 8'h03);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
